// File: rtl/serial_negate_pkg.sv
// Shared types and helpers for the serial negate / abs unit.
// Optional macro SERIAL_NEGATE_SAT_EN is consumed by serial_negate.
package serial_negate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_NEG = 1'b0;
  localparam logic MODE_ABS = 1'b1;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of the digit slice.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_negate_digit.sv
// negate_digit: DIGIT-wide conditional invert-and-increment slice,
// a ripple chain of full adders with the B operand tied low.
module negate_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] y,
  output logic             cout
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .i_a    (a[i] ^ inv),
      .i_b    (1'b0),
      .i_cin  (w_c[i]),
      .o_sum  (y[i]),
      .o_cout (w_c[i+1])
    );
  end

  assign cout = w_c[DIGIT];

endmodule

// File: rtl/serial_negate.sv
// Multi-cycle two's-complement negate / abs, DIGIT bits per cycle.
// Define SERIAL_NEGATE_SAT_EN to saturate the overflow case to max positive.
module serial_negate
  import serial_negate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_negate: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_negate: WIDTH must be divisible by DIGIT");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_y;
  logic [CW-1:0]    r_cnt;
  logic             r_inv;
  logic             r_carry;
  logic             r_min;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_inv;
  logic [DIGIT-1:0] w_dy;
  logic             w_cout;
  logic [WIDTH-1:0] w_dy_ext;
  logic [WIDTH-1:0] w_y_shift;
  logic [WIDTH-1:0] w_y_fin;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_y     = r_y;
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);
  assign w_inv    = (in_mode == MODE_NEG) ||
                    ((in_mode == MODE_ABS) && in_a[WIDTH-1]);

  // r_a shifts right each cycle so the active digit is always the LSBs
  negate_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (r_a[DIGIT-1:0]),
    .inv  (r_inv),
    .cin  (r_carry),
    .y    (w_dy),
    .cout (w_cout)
  );

  always_comb begin
    w_dy_ext = '0;
    w_dy_ext[WIDTH-1 -: DIGIT] = w_dy;
    w_y_shift = (r_y >> DIGIT) | w_dy_ext;
    w_y_fin = w_y_shift;
`ifdef SERIAL_NEGATE_SAT_EN
    if (r_min) w_y_fin = MAX_POS;
`else
    if (r_min) w_y_fin = MIN_NEG;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_carry <= 1'b0;
      r_min   <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_a     <= in_a;
          r_y     <= '0;
          r_cnt   <= '0;
          r_inv   <= w_inv;
          r_carry <= w_inv;
          r_min   <= w_inv && (in_a == MIN_NEG);
          r_ovf   <= 1'b0;
          r_zero  <= 1'b0;
        end
        BUSY: begin
          r_a     <= r_a >> DIGIT;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_y    <= w_y_fin;
            r_ovf  <= r_min;
            r_zero <= (w_y_fin == '0);
          end else begin
            r_y <= w_y_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
